// File: rtl/ram_arb2.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM.
// Round-robin grants with per-requester burst lock and tagged read return.
module ram_arb2 #(
    parameter int RAM_LAT = 2,
    parameter int AW      = 9,
    parameter int DW      = 16
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          ram_cen,
    output logic          ram_rw,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // state | meaning
    // NONE  | no owner; round-robin between eligible requesters
    // OWN0  | requester 0 holds a lock; granted every cycle while req0
    // OWN1  | requester 1 holds a lock; granted every cycle while req1
    typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             gnt0;
    logic             gnt1;
    logic             elig0;
    logic             elig1;
    logic [RAM_LAT:0] tag_v;
    logic [RAM_LAT:0] tag_id;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) state <= NONE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NONE: begin
                if (gnt0 && lock0)      state_nxt = OWN0;
                else if (gnt1 && lock1) state_nxt = OWN1;
            end
            OWN0:    if (!req0 || !lock0) state_nxt = NONE;
            OWN1:    if (!req1 || !lock1) state_nxt = NONE;
            default: state_nxt = NONE;
        endcase
    end

    // Unlocked requests are masked in their ack cycle: the requester is still
    // holding the access that was just issued. A locked requester instead
    // presents its next access during the ack cycle.
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            NONE: begin
                if (elig0 && (!elig1 || !rr_ptr)) gnt0 = 1'b1;
                else if (elig1)                   gnt1 = 1'b1;
            end
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rr_ptr  <= 1'b0;
            ram_cen <= 1'b1;
            ram_rw  <= 1'b1;
            ram_a   <= '0;
            ram_din <= '0;
        end else begin
            ack0 <= gnt0;
            ack1 <= gnt1;
            if (gnt0 || gnt1) begin
                rr_ptr  <= gnt0;
                ram_cen <= 1'b0;
                ram_rw  <= gnt0 ? !wr0 : !wr1;
                ram_a   <= gnt0 ? addr0 : addr1;
                ram_din <= gnt0 ? wdata0 : wdata1;
            end else begin
                ram_cen <= 1'b1;
                ram_rw  <= 1'b1;
            end
        end
    end

    // Tag stage k is visible k+1 cycles after the grant; the last stage lines
    // up with valid data on ram_dout.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            tag_v   <= '0;
            tag_id  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            tag_v   <= {tag_v[RAM_LAT-1:0], (gnt0 && !wr0) || (gnt1 && !wr1)};
            tag_id  <= {tag_id[RAM_LAT-1:0], gnt1};
            rvalid0 <= tag_v[RAM_LAT] && !tag_id[RAM_LAT];
            rvalid1 <= tag_v[RAM_LAT] && tag_id[RAM_LAT];
            if (tag_v[RAM_LAT]) rdata <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a 2-cycle RAM model; checks at negedge.
module tb_ram_arb2;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          sys_clk = 1'b0;
    logic          resetl;
    logic          req0, req1, wr0, wr1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_cen, ram_rw;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] rd_stage;

    int errors = 0;
    int checks = 0;
    int n_ack0;
    int n_ack1;

    ram_arb2 #(.RAM_LAT(2), .AW(AW), .DW(DW)) dut (
        .sys_clk(sys_clk), .resetl(resetl),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_cen(ram_cen), .ram_rw(ram_rw), .ram_a(ram_a),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM: writes at the sampling edge, read data on ram_dout two edges later.
    always @(posedge sys_clk) begin
        if (!ram_cen) begin
            if (!ram_rw) mem[ram_a] <= ram_din;
            else         rd_stage   <= mem[ram_a];
        end
        ram_dout <= rd_stage;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ack0"}, 32'(ack0), 0);
        check({tag, " ack1"}, 32'(ack1), 0);
        check({tag, " rvalid0"}, 32'(rvalid0), 0);
        check({tag, " rvalid1"}, 32'(rvalid1), 0);
        check({tag, " rdata"}, 32'(rdata), 0);
        check({tag, " ram_cen"}, 32'(ram_cen), 1);
        check({tag, " ram_rw"}, 32'(ram_rw), 1);
        check({tag, " ram_a"}, 32'(ram_a), 0);
        check({tag, " ram_din"}, 32'(ram_din), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3 + 7);
        mem[9'h005] = 16'h1234;
        mem[9'h010] = 16'hA010;
        mem[9'h011] = 16'hA011;
        mem[9'h012] = 16'hA012;
        mem[9'h013] = 16'hA013;
        mem[9'h020] = 16'hC020;
        rd_stage = '0;
        resetl = 1'b1;
        {req0, req1, wr0, wr1, lock0, lock1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #1 resetl = 1'b0;
        #1 check_reset_vals("reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        resetl = 1'b1;

        // Idle
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle cen", 32'(ram_cen), 1);
            check("idle rw", 32'(ram_rw), 1);
            check("idle ack", 32'({ack0, ack1}), 0);
            check("idle rvalid", 32'({rvalid0, rvalid1}), 0);
        end

        // Single read by requester 0
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h005;
        tick();
        check("rd ack0", 32'(ack0), 1);
        check("rd ack1", 32'(ack1), 0);
        check("rd cen", 32'(ram_cen), 0);
        check("rd rw", 32'(ram_rw), 1);
        check("rd addr", 32'(ram_a), 32'h005);
        req0 = 1'b0;
        tick();
        check("rd ack0 single", 32'(ack0), 0);
        check("rd cen release", 32'(ram_cen), 1);
        check("rd rvalid early2", 32'({rvalid0, rvalid1}), 0);
        tick();
        check("rd rvalid early3", 32'({rvalid0, rvalid1}), 0);
        tick();
        check("rd rvalid0", 32'(rvalid0), 1);
        check("rd rvalid1", 32'(rvalid1), 0);
        check("rd rdata", 32'(rdata), 32'h1234);

        // Write then read on requester 1 (locked so the read follows at once)
        req1 = 1'b1; wr1 = 1'b1; lock1 = 1'b1; addr1 = 9'h1FF; wdata1 = 16'hBEEF;
        tick();
        check("wr ack1", 32'(ack1), 1);
        check("wr cen", 32'(ram_cen), 0);
        check("wr rw", 32'(ram_rw), 0);
        check("wr addr", 32'(ram_a), 32'h1FF);
        check("wr din", 32'(ram_din), 32'hBEEF);
        wr1 = 1'b0; lock1 = 1'b0;
        tick();
        check("wr-rd ack1", 32'(ack1), 1);
        check("wr-rd rw", 32'(ram_rw), 1);
        check("wr-rd addr", 32'(ram_a), 32'h1FF);
        req1 = 1'b0;
        tick();
        check("wr-rd ack done", 32'(ack1), 0);
        check("wr-rd no rvalid for write", 32'({rvalid0, rvalid1}), 0);
        tick();
        check("wr-rd rvalid early", 32'({rvalid0, rvalid1}), 0);
        tick();
        check("wr-rd rvalid1", 32'(rvalid1), 1);
        check("wr-rd rvalid0", 32'(rvalid0), 0);
        check("wr-rd rdata", 32'(rdata), 32'hBEEF);

        // Locked burst of 4 reads by requester 1 while requester 0 waits
        req1 = 1'b1; wr1 = 1'b0; lock1 = 1'b1; addr1 = 9'h010;
        tick();
        check("burst ack1 a", 32'(ack1), 1);
        check("burst addr a", 32'(ram_a), 32'h010);
        addr1 = 9'h011;
        req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b0; addr0 = 9'h020;
        tick();
        check("burst ack b", 32'({ack0, ack1}), 32'b01);
        check("burst addr b", 32'(ram_a), 32'h011);
        addr1 = 9'h012;
        tick();
        check("burst ack c", 32'({ack0, ack1}), 32'b01);
        check("burst addr c", 32'(ram_a), 32'h012);
        addr1 = 9'h013; lock1 = 1'b0;
        tick();
        check("burst ack d", 32'({ack0, ack1}), 32'b01);
        check("burst addr d", 32'(ram_a), 32'h013);
        check("burst rvalid1 a", 32'({rvalid0, rvalid1}), 32'b01);
        check("burst rdata a", 32'(rdata), 32'hA010);
        req1 = 1'b0;
        tick();
        check("burst then ack0", 32'({ack0, ack1}), 32'b10);
        check("burst ack0 addr", 32'(ram_a), 32'h020);
        check("burst rvalid1 b", 32'({rvalid0, rvalid1}), 32'b01);
        check("burst rdata b", 32'(rdata), 32'hA011);
        req0 = 1'b0;
        tick();
        check("burst rvalid1 c", 32'({rvalid0, rvalid1}), 32'b01);
        check("burst rdata c", 32'(rdata), 32'hA012);
        tick();
        check("burst rvalid1 d", 32'({rvalid0, rvalid1}), 32'b01);
        check("burst rdata d", 32'(rdata), 32'hA013);
        tick();
        check("burst rvalid0", 32'({rvalid0, rvalid1}), 32'b10);
        check("burst rdata0", 32'(rdata), 32'hC020);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle hold cen", 32'(ram_cen), 1);
            check("idle hold addr", 32'(ram_a), 32'h020);
            check("idle hold rvalid", 32'({rvalid0, rvalid1}), 0);
        end

        // Reset one cycle after a read ack
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h005;
        tick();
        check("rst-rd ack0", 32'(ack0), 1);
        req0 = 1'b0;
        tick();
        resetl = 1'b0;
        #1 check_reset_vals("mid reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        resetl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post-reset rvalid", 32'({rvalid0, rvalid1}), 0);
        end

        // Contention, unlocked: acks alternate starting with requester 0
        n_ack0 = 0;
        n_ack1 = 0;
        req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b0; addr0 = 9'h005;
        req1 = 1'b1; wr1 = 1'b0; lock1 = 1'b0; addr1 = 9'h1FF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("contend acks", 32'({ack0, ack1}), (i % 2 == 1) ? 32'b10 : 32'b01);
            n_ack0 += int'(ack0);
            n_ack1 += int'(ack1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("contend count0", 32'(n_ack0), 4);
        check("contend count1", 32'(n_ack1), 4);
        tick();
        check("contend stop", 32'({ack0, ack1}), 0);
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
